// File: rtl/cr_isf_dbg_trig.sv
// cr_isf_dbg_trig: ISF inbound debug trigger with a stallable, single-steppable one-register stage
// Ports: trig_en/ss_en/trig_tlv/trig_match/trig_mask/rearm/single_step_rd come from the regfile debug config;
//        in_* is the upstream valid/ready stream; out_* is the registered downstream stream;
//        trig_cap/ss_cap/ss_cap_sb/trig_cnt/state/stall are regfile readback.
module cr_isf_dbg_trig #(
  parameter int DATA_W = 64,
  parameter int TLV_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_en,
  input  logic              ss_en,
  input  logic [TLV_W-1:0]  trig_tlv,
  input  logic [DATA_W-1:0] trig_match,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic              rearm,
  input  logic              single_step_rd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TLV_W-1:0]  in_tlv,
  input  logic              in_sot,
  input  logic              in_eot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TLV_W-1:0]  out_tlv,
  output logic              out_sot,
  output logic              out_eot,
  output logic [DATA_W-1:0] trig_cap,
  output logic [DATA_W-1:0] ss_cap,
  output logic [TLV_W+1:0]  ss_cap_sb,
  output logic [CNT_W-1:0]  trig_cnt,
  output logic [1:0]        state,
  output logic              stall
);
  typedef enum logic [1:0] {IDLE, ARMED, FIRED, HOLD} state_t;
  state_t st, st_nxt;
  logic credit, credit_nxt, acc, hit, fire, held;
  assign held = st == HOLD;
  assign in_ready = (!out_valid | out_ready) & (!held | credit);
  assign acc = in_valid & in_ready;
  assign hit = acc & (in_tlv == trig_tlv) & ~|((in_data ^ trig_match) & trig_mask);
  assign fire = trig_en & (st == ARMED) & hit;
  assign state = st;
  assign stall = held;
  always_comb begin
    st_nxt = !trig_en ? IDLE :
             rearm & (st == FIRED | held) ? ARMED :
             held & !ss_en ? FIRED :
             st == IDLE ? ARMED :
             fire ? (ss_en ? HOLD : FIRED) : st;
    credit_nxt = (st_nxt == HOLD) & ((credit & ~acc) | (single_step_rd & held));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      credit <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_tlv <= '0;
      out_sot <= 1'b0;
      out_eot <= 1'b0;
      trig_cap <= '0;
      trig_cnt <= '0;
      ss_cap <= '0;
      ss_cap_sb <= '0;
    end else begin
      st <= st_nxt;
      credit <= credit_nxt;
      if (acc) begin
        out_valid <= 1'b1;
        out_data <= in_data;
        out_tlv <= in_tlv;
        out_sot <= in_sot;
        out_eot <= in_eot;
      end else if (out_ready) out_valid <= 1'b0;
      if (fire) begin
        trig_cap <= in_data;
        trig_cnt <= trig_cnt + CNT_W'(~&trig_cnt);
      end
      if (acc & held) begin
        ss_cap <= in_data;
        ss_cap_sb <= {in_tlv, in_sot, in_eot};
      end
    end
  end
endmodule

// File: tb/tb_cr_isf_dbg_trig.sv
// tb_cr_isf_dbg_trig: directed bench with a scoreboard model of the debug trigger stage
module tb_cr_isf_dbg_trig;
  logic clk = 0, rst = 1, trig_en = 0, ss_en = 0, rearm = 0, single_step_rd = 0;
  logic in_valid = 0, in_sot = 0, in_eot = 0, out_ready = 1;
  logic [7:0] trig_tlv = 0, in_tlv = 0;
  logic [63:0] trig_match = 0, trig_mask = 0, in_data = 0;
  logic in_ready, out_valid, out_sot, out_eot, stall;
  logic [7:0] out_tlv;
  logic [63:0] out_data, trig_cap, ss_cap;
  logic [9:0] ss_cap_sb;
  logic [15:0] trig_cnt;
  logic [1:0] state;
  logic s_in_ready, s_out_valid, s_out_sot, s_out_eot, s_stall;
  logic [7:0] s_out_tlv;
  logic [63:0] s_out_data, s_trig_cap, s_ss_cap;
  logic [9:0] s_ss_cap_sb;
  logic [3:0] s_trig_cnt;
  logic [1:0] s_state;

  cr_isf_dbg_trig dut (
    .clk(clk), .rst(rst), .trig_en(trig_en), .ss_en(ss_en), .trig_tlv(trig_tlv),
    .trig_match(trig_match), .trig_mask(trig_mask), .rearm(rearm), .single_step_rd(single_step_rd),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tlv(in_tlv),
    .in_sot(in_sot), .in_eot(in_eot), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tlv(out_tlv), .out_sot(out_sot), .out_eot(out_eot),
    .trig_cap(trig_cap), .ss_cap(ss_cap), .ss_cap_sb(ss_cap_sb), .trig_cnt(trig_cnt),
    .state(state), .stall(stall)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  cr_isf_dbg_trig #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .trig_en(trig_en), .ss_en(ss_en), .trig_tlv(trig_tlv),
    .trig_match(trig_match), .trig_mask(trig_mask), .rearm(rearm), .single_step_rd(single_step_rd),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_tlv(in_tlv),
    .in_sot(in_sot), .in_eot(in_eot), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_tlv(s_out_tlv), .out_sot(s_out_sot), .out_eot(s_out_eot),
    .trig_cap(s_trig_cap), .ss_cap(s_ss_cap), .ss_cap_sb(s_ss_cap_sb), .trig_cnt(s_trig_cnt),
    .state(s_state), .stall(s_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] tlv;
    logic sot;
    logic eot;
    logic [63:0] data;
  } word_t;

  word_t q[$];
  word_t m_last;
  int m_st, m_cnt, n_chk, n_fail, dlv, d0;
  bit m_cr, m_live;
  logic [63:0] m_tcap, m_scap;
  logic [9:0] m_ssb;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit m_ready();
    return (q.size() == 0 || out_ready) && (m_st != 3 || m_cr);
  endfunction

  always @(posedge clk) begin
    bit acc, hit;
    int nx;
    if (rst) begin
      q.delete();
      m_last = '0; m_st = 0; m_cr = 0; m_tcap = 0; m_scap = 0; m_ssb = 0; m_cnt = 0; m_live = 1;
    end else if (m_live) begin
      acc = in_valid && m_ready();
      hit = acc && in_tlv == trig_tlv && ((in_data ^ trig_match) & trig_mask) == 0;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        m_last = {in_tlv, in_sot, in_eot, in_data};
        q.push_back(m_last);
      end
      if (trig_en && m_st == 1 && hit) begin
        m_tcap = in_data;
        m_cnt = m_cnt < 65535 ? m_cnt + 1 : 65535;
      end
      if (acc && m_st == 3) begin
        m_scap = in_data;
        m_ssb = {in_tlv, in_sot, in_eot};
      end
      if (!trig_en) nx = 0;
      else if (rearm && m_st >= 2) nx = 1;
      else if (m_st == 3 && !ss_en) nx = 2;
      else if (m_st == 0) nx = 1;
      else if (m_st == 1 && hit) nx = ss_en ? 3 : 2;
      else nx = m_st;
      m_cr = nx == 3 && ((m_cr && !acc) || (single_step_rd && m_st == 3));
      m_st = nx;
    end
  end

  always @(negedge clk) begin
    if (m_live && !rst) begin
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_data", out_data, m_last.data);
      chk("out_tlv", out_tlv, m_last.tlv);
      chk("out_sot", out_sot, m_last.sot);
      chk("out_eot", out_eot, m_last.eot);
      chk("state", state, m_st);
      chk("stall", stall, m_st == 3);
      chk("trig_cap", trig_cap, m_tcap);
      chk("trig_cnt", trig_cnt, m_cnt);
      chk("ss_cap", ss_cap, m_scap);
      chk("ss_cap_sb", ss_cap_sb, m_ssb);
      if (out_valid && out_ready) dlv++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] t, input logic [63:0] d, input logic s, input logic e);
    bit done = 0;
    in_valid = 1; in_tlv = t; in_data = d; in_sot = s; in_eot = e;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = in_ready;
      tick();
    end
    in_valid = 0;
    chk("send_accept", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_state", state, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_trig_cnt", trig_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) send(8'd1, 64'h100 + i, i == 0, i == 3);
    tick();
    chk("idle_dlv", dlv, 4);
    chk("idle_last", out_data, 64'h103);
    chk("idle_cap", trig_cap, 0);
    chk("idle_state", state, 0);
    trig_en = 1; trig_tlv = 5; trig_mask = 64'hFFFF; trig_match = 64'h1234;
    tick();
    chk("armed_state", state, 1);
    send(8'd6, 64'hAB1234, 1, 1);
    chk("wrong_tlv_state", state, 1);
    chk("wrong_tlv_cnt", trig_cnt, 0);
    send(8'd5, 64'hAB1234, 1, 1);
    chk("fire_state", state, 2);
    chk("fire_cap", trig_cap, 64'hAB1234);
    chk("fire_cnt", trig_cnt, 1);
    ss_en = 1; rearm = 1;
    tick();
    rearm = 0;
    chk("rearm_state", state, 1);
    send(8'd5, 64'h5555_1234, 1, 1);
    chk("hold_state", state, 3);
    chk("hold_stall", stall, 1);
    chk("hold_ready", in_ready, 0);
    single_step_rd = 1; tick();
    single_step_rd = 0; tick();
    single_step_rd = 1; tick();
    single_step_rd = 0;
    d0 = dlv;
    in_valid = 1; in_tlv = 2; in_data = 64'hA1; in_sot = 1; in_eot = 0;
    tick();
    in_data = 64'hA2; in_sot = 0; in_eot = 1;
    tick(); tick(); tick();
    chk("step_dlv", dlv - d0, 1);
    chk("step_cap", ss_cap, 64'hA1);
    chk("step_sb", ss_cap_sb, {8'h02, 1'b1, 1'b0});
    chk("step_ready", in_ready, 0);
    d0 = dlv;
    single_step_rd = 1; tick();
    single_step_rd = 0; tick();
    out_ready = 0; in_data = 64'hA3; single_step_rd = 1;
    tick();
    single_step_rd = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", out_data, 64'hA2);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      tick();
    end
    out_ready = 1;
    tick();
    chk("bp_next", out_data, 64'hA3);
    chk("bp_used", in_ready, 0);
    in_valid = 0;
    tick();
    chk("bp_dlv", dlv - d0, 2);
    single_step_rd = 1; tick();
    single_step_rd = 0;
    chk("exit_credit", in_ready, 1);
    trig_en = 0;
    tick();
    chk("exit_state", state, 0);
    chk("exit_stall", stall, 0);
    chk("exit_ready", in_ready, 1);
    send(8'd1, 64'hB0, 1, 1);
    trig_en = 1;
    tick();
    send(8'd5, 64'h9_1234, 1, 1);
    chk("rehold_state", state, 3);
    chk("rehold_no_credit", in_ready, 0);
    ss_en = 0;
    tick();
    chk("release_state", state, 2);
    rearm = 1; tick(); rearm = 0;
    ss_en = 1;
    send(8'd5, 64'h77_1234, 1, 1);
    out_ready = 0;
    tick();
    chk("pre_rst_state", state, 3);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_cap", trig_cap, 0);
    chk("mid_rst_cnt", trig_cnt, 0);
    chk("mid_rst_ss", ss_cap, 0);
    chk("mid_rst_sb", ss_cap_sb, 0);
    chk("mid_rst_sat", s_trig_cnt, 0);
    out_ready = 1; ss_en = 0; trig_mask = 0; in_tlv = 5; in_data = 64'hDEAD_BEEF; in_valid = 1; rearm = 1;
    repeat (40) tick();
    chk("hits_cnt", trig_cnt, 20);
    chk("sat_cnt", s_trig_cnt, 15);
    in_valid = 0; rearm = 0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
